multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM and decoders for the multicycle RV32I core.
- Sequences one shared ALU, one unified memory port and the datapath's 2/3/4-input select muxes through the fetch, decode, execute, memory and writeback steps of each instruction.
- Drives every mux select, register enable and memory handshake signal in the datapath.
- Outputs are Moore-style, decoded from the current state; memory enables are also qualified by mem_ready.

Parameters:
- TRAP_ON_ILLEGAL, 1. When 1, an illegal instruction sends the FSM to TRAP. When 0, it is retired as a NOP (DECODE->FETCH).

Ports:
- clk  in  1  Core clock; all state updates on the rising edge.
- rst_n  in  1  Synchronous, active-low reset.
- op  in  7  Opcode field from the instruction register.
- funct3  in  3  Instruction bits [14:12].
- funct7b5  in  1  Instruction bit 30.
- zero  in  1  ALU result == 0.
- lt  in  1  ALU signed less-than.
- ltu  in  1  ALU unsigned less-than.
- mem_ready  in  1  Memory completes the current access this cycle.
- mem_req  out  1  Memory access request.
- mem_write  out  1  Memory access is a write.
- adr_src  out  1  Memory address select: 0 = PC, 1 = Result.
- ir_write  out  1  Load the instruction register and OldPC.
- pc_write  out  1  Load the PC from Result.
- reg_write  out  1  Register-file write enable.
- alu_src_a  out  2  ALU operand A: 00 = PC, 01 = OldPC, 10 = rs1 register A.
- alu_src_b  out  2  ALU operand B: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- result_src  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- alu_control  out  4  ALU operation code.
- imm_src  out  3  Immediate format: I = 000, S = 001, B = 010, J = 011, U = 100.
- illegal_instr  out  1  High while in TRAP.

Behaviour:
- State after reset:
  - rst_n low at a clock edge sets state to FETCH.
  - While rst_n is low, mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0.
  - Reset mid-instruction abandons the instruction; no partial register or memory write is issued after the reset edge.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
- FETCH:
  - Outputs: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, add, result_src = 10.
  - On a cycle with mem_ready = 1: ir_write = 1, pc_write = 1, go to DECODE.
  - Otherwise ir_write and pc_write stay 0 and the FSM waits in FETCH.
- DECODE:
  - Outputs: alu_src_a = 01, alu_src_b = 01, add (ALUOut = OldPC + imm).
  - Next state by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - 0001111 (fence) -> FETCH
    - any other opcode, or a branch with funct3 010/011 -> illegal handling per TRAP_ON_ILLEGAL
- MEMADR: rs1 + imm (alu_src_a = 10, alu_src_b = 01, add). Next state is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req = 1, adr_src = 1, result_src = 00. Wait until mem_ready, then go to MEMWB.
- MEMWB: result_src = 01, reg_write = 1, then FETCH.
- MEMWRITE: mem_req = mem_write = 1, adr_src = 1, result_src = 00. Wait until mem_ready, then go to FETCH.
- EXECUTER: alu_src_a = 10, alu_src_b = 00, ALU op from funct3/funct7b5. Then ALUWB.
- EXECUTEI: as EXECUTER but with alu_src_b = 01. Then ALUWB.
- ALUWB: result_src = 00, reg_write = 1, then FETCH.
- BRANCH:
  - rs1 - rs2 (alu_src_a = 10, alu_src_b = 00, sub), result_src = 00.
  - pc_write = taken, where taken is decided by funct3:
    - 000 = zero
    - 001 = !zero
    - 100 = lt
    - 101 = !lt
    - 110 = ltu
    - 111 = !ltu
  - Then FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1 (target held in ALUOut). Then ALUWB (rd = OldPC + 4).
- JALR: rs1 + imm into ALUOut (alu_src_a = 10, alu_src_b = 01). Then JAL.
- LUI: result_src = 11, reg_write = 1, then FETCH.
- AUIPC: alu_src_a = 01, alu_src_b = 01, add, then ALUWB.
- TRAP: illegal_instr = 1, all enables 0. Stays in TRAP until reset.
- alu_control codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- ALU op by funct3 in EXECUTER/EXECUTEI:
  - 000: sub only for R-type with funct7b5 = 1; add otherwise.
  - 101: sra if funct7b5 = 1, else srl (both R-type and I-type).
- imm_src is combinational from op in every state:
  - I for loads, OP-IMM and JALR
  - S for stores, B for branches, J for JAL, U for LUI/AUIPC
  - 000 otherwise
- Cycle counts with mem_ready held at 1:
  - R-type / I-type / store / jal / auipc = 4
  - load / jalr = 5
  - branch / lui = 3
  - Each memory wait cycle adds 1.

Test Plan:
- Reset then addi x1,x0,5 with mem_ready = 1 -> states FETCH, DECODE, EXECUTEI, ALUWB; reg_write only in cycle 4; alu_control = 0000, imm_src = 000.
- lw with mem_ready low for 2 cycles in MEMREAD -> mem_req held 3 cycles, adr_src = 1; reg_write with result_src = 01 exactly one cycle after ready; total 7 cycles.
- beq, zero = 1 -> pc_write = 1 in BRANCH. Same instruction with zero = 0 -> pc_write = 0. Both return to FETCH after 3 cycles.
- sub (funct7b5 = 1, funct3 = 000) -> alu_control = 0001. srai (op 0010011, funct3 = 101, funct7b5 = 1) -> 1001. jalr -> JALR then JAL (pc_write = 1) then ALUWB.
- Opcode 1110011 with TRAP_ON_ILLEGAL = 1 -> TRAP, illegal_instr = 1, no enables asserted for 20 cycles. With TRAP_ON_ILLEGAL = 0 -> back to FETCH after DECODE.
- rst_n low during MEMWRITE with mem_ready = 0 -> next state FETCH; mem_write = 0 from the reset edge on; first fetch issues after rst_n is released.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU, memory port and datapath muxes.
// Outputs are decoded from the current state; memory-side enables are also qualified by mem_ready.
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
        ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? TRAP : FETCH;

    state_t     state_q, state_d;
    logic [3:0] alu_op;
    logic       taken;
    logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Only R-type turns funct3=000 into sub; shifts honour funct7b5 for both formats.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (state_q == EXECUTER && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: imm_src = 3'b000;
            OP_STORE:                 imm_src = 3'b001;
            OP_BRANCH:                imm_src = 3'b010;
            OP_JAL:                   imm_src = 3'b011;
            OP_LUI, OP_AUIPC:         imm_src = 3'b100;
            default:                  imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_req_c     = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_control   = ALU_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_REG:            state_d = EXECUTER;
                    OP_IMM:            state_d = EXECUTEI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? ILLEGAL_NEXT : BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    OP_FENCE:          state_d = FETCH;
                    default:           state_d = ILLEGAL_NEXT;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op;
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write_c  = taken;
                state_d     = FETCH;
            end
            // Target already sits in ALUOut; the ALU now forms the link value OldPC + 4.
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = JAL;
            end
            LUI: begin
                result_src  = 2'b11;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = ALUWB;
            end
            TRAP: begin
                illegal_instr = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset suppresses every side effect immediately, even before the state register clears.
    assign mem_req   = mem_req_c   & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign pc_write  = pc_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;

endmodule
